// File: rtl/asiclab_pkg.sv
// Shared constants and FSM encoding for the nibble-sum readout path.
package asiclab_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ACC_W  = 6;
    localparam int COUNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_sum_accumulator_sat_add.sv
// Combinational unsigned saturating adder; carry flags that the true sum did not fit in W bits.
module sat_add #(
    parameter int W   = 6,
    parameter int B_W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [B_W-1:0] b,
    output logic [W-1:0]   sum,
    output logic           carry
);

    logic [W:0] full;

    assign full  = {1'b0, a} + {{(W + 1 - B_W){1'b0}}, b};
    assign carry = full[W];
    assign sum   = carry ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/nibble_sum_accumulator.sv
// Windowed saturating accumulator for 4-bit nibble sums with valid/ready on both sides.
module nibble_sum_accumulator
    import asiclab_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int NUM_SAMPLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_ovf
);

    state_t             state, state_next;
    logic               armed;
    logic [ACC_W-1:0]   acc, acc_next, sum_sat;
    logic [COUNT_W-1:0] count, count_next;
    logic               ovf, ovf_next, carry;
    logic               accept, take;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    sat_add #(.W(ACC_W), .B_W(DATA_W)) u_sat_add (
        .a     (acc),
        .b     (in_data),
        .sum   (sum_sat),
        .carry (carry)
    );

    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        count_next = count;
        ovf_next   = ovf;
        if (clear) begin
            state_next = ACCUM;
            acc_next   = '0;
            count_next = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                // armed holds IDLE for one full cycle after reset release
                IDLE: if (armed) state_next = ACCUM;
                ACCUM: if (accept) begin
                    acc_next   = sum_sat;
                    count_next = count + COUNT_W'(1);
                    ovf_next   = ovf | carry;
                    if (count_next == COUNT_W'(NUM_SAMPLES)) state_next = HOLD;
                end
                HOLD: if (take) begin
                    state_next = ACCUM;
                    acc_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            armed     <= 1'b0;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            armed     <= 1'b1;
            acc       <= acc_next;
            count     <= count_next;
            ovf       <= ovf_next;
            in_ready  <= (state_next == ACCUM);
            out_valid <= (state_next == HOLD);
        end
    end

    assign out_sum   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

endmodule
